// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-client MemDPI arbiter.
package mem_arb_pkg;

    localparam int unsigned MEM_LEN_BITS_DEF  = 8;
    localparam int unsigned MEM_ADDR_BITS_DEF = 32;
    localparam int unsigned MEM_DATA_BITS_DEF = 64;

    localparam logic MEM_OP_RD = 1'b0;
    localparam logic MEM_OP_WR = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StRd,
        StWr
    } arb_state_e;

    typedef struct packed {
        logic                         opcode;
        logic [MEM_LEN_BITS_DEF-1:0]  len;
        logic [MEM_ADDR_BITS_DEF-1:0] addr;
    } mem_req_t;

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-input round-robin grant; the pointer flips away from whichever client was just granted.
module mem_arb_rr2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    logic ptr_q, ptr_d;

    always_comb begin
        gnt_valid = |req;
        gnt_idx   = (&req) ? ptr_q : req[1];
        ptr_d     = ptr_q;
        if (advance && gnt_valid) begin
            ptr_d = ~gnt_idx;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one MemDPI port between two engines, one burst per grant.
// Define MEM_ARB_BUSY_CNT_EN to build the saturating busy_cycles counter.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_LEN_BITS  = MEM_LEN_BITS_DEF,
    parameter int unsigned MEM_ADDR_BITS = MEM_ADDR_BITS_DEF,
    parameter int unsigned MEM_DATA_BITS = MEM_DATA_BITS_DEF
) (
    input  logic                     clock,
    input  logic                     reset,

    input  logic                     c0_req_valid,
    input  logic                     c0_req_opcode,
    input  logic [MEM_LEN_BITS-1:0]  c0_req_len,
    input  logic [MEM_ADDR_BITS-1:0] c0_req_addr,
    output logic                     c0_req_ack,
    input  logic                     c0_wr_valid,
    input  logic [MEM_DATA_BITS-1:0] c0_wr_bits,
    output logic                     c0_wr_ready,
    output logic                     c0_rd_valid,
    output logic [MEM_DATA_BITS-1:0] c0_rd_bits,
    input  logic                     c0_rd_ready,

    input  logic                     c1_req_valid,
    input  logic                     c1_req_opcode,
    input  logic [MEM_LEN_BITS-1:0]  c1_req_len,
    input  logic [MEM_ADDR_BITS-1:0] c1_req_addr,
    output logic                     c1_req_ack,
    input  logic                     c1_wr_valid,
    input  logic [MEM_DATA_BITS-1:0] c1_wr_bits,
    output logic                     c1_wr_ready,
    output logic                     c1_rd_valid,
    output logic [MEM_DATA_BITS-1:0] c1_rd_bits,
    input  logic                     c1_rd_ready,

    output logic                     mem_req_valid,
    output logic                     mem_req_opcode,
    output logic [MEM_LEN_BITS-1:0]  mem_req_len,
    output logic [MEM_ADDR_BITS-1:0] mem_req_addr,
    output logic                     mem_wr_valid,
    output logic [MEM_DATA_BITS-1:0] mem_wr_bits,
    input  logic                     mem_rd_valid,
    input  logic [MEM_DATA_BITS-1:0] mem_rd_bits,
    output logic                     mem_rd_ready,

    output logic [31:0]              busy_cycles
);

    arb_state_e              state_q, state_d;
    logic                    owner_q, owner_d;
    logic [MEM_LEN_BITS-1:0] cnt_q, cnt_d;
    mem_req_t                req_q, req_d;
    mem_req_t                c0_fields, c1_fields;

    logic rr_advance;
    logic gnt_valid;
    logic gnt_idx;

    assign c0_fields = {c0_req_opcode, c0_req_len, c0_req_addr};
    assign c1_fields = {c1_req_opcode, c1_req_len, c1_req_addr};

    mem_arb_rr2 u_rr (
        .clock     (clock),
        .reset     (reset),
        .req       ({c1_req_valid, c0_req_valid}),
        .advance   (rr_advance),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        cnt_d          = cnt_q;
        req_d          = req_q;
        rr_advance     = 1'b0;
        mem_req_valid  = 1'b0;
        mem_req_opcode = 1'b0;
        mem_req_len    = '0;
        mem_req_addr   = '0;
        mem_wr_valid   = 1'b0;
        mem_wr_bits    = '0;
        mem_rd_ready   = 1'b0;
        c0_req_ack     = 1'b0;
        c1_req_ack     = 1'b0;
        c0_wr_ready    = 1'b0;
        c1_wr_ready    = 1'b0;
        c0_rd_valid    = 1'b0;
        c1_rd_valid    = 1'b0;
        c0_rd_bits     = '0;
        c1_rd_bits     = '0;

        case (state_q)
            StIdle: begin
                rr_advance = 1'b1;
                if (gnt_valid) begin
                    owner_d = gnt_idx;
                    req_d   = gnt_idx ? c1_fields : c0_fields;
                    state_d = StReq;
                end
            end
            StReq: begin
                mem_req_valid  = 1'b1;
                mem_req_opcode = req_q.opcode;
                mem_req_len    = req_q.len;
                mem_req_addr   = req_q.addr;
                c0_req_ack     = ~owner_q;
                c1_req_ack     = owner_q;
                cnt_d          = '0;
                state_d        = (req_q.opcode == MEM_OP_WR) ? StWr : StRd;
            end
            StRd: begin
                mem_rd_ready = owner_q ? c1_rd_ready : c0_rd_ready;
                c0_rd_valid  = ~owner_q & mem_rd_valid;
                c1_rd_valid  = owner_q & mem_rd_valid;
                c0_rd_bits   = mem_rd_bits;
                c1_rd_bits   = mem_rd_bits;
                if (mem_rd_valid && mem_rd_ready) begin
                    if (cnt_q == req_q.len) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StWr: begin
                c0_wr_ready  = ~owner_q;
                c1_wr_ready  = owner_q;
                mem_wr_valid = owner_q ? c1_wr_valid : c0_wr_valid;
                mem_wr_bits  = owner_q ? c1_wr_bits : c0_wr_bits;
                // Memory never backpressures writes, so every valid beat counts.
                if (mem_wr_valid) begin
                    if (cnt_q == req_q.len) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            cnt_q   <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

`ifdef MEM_ARB_BUSY_CNT_EN
    logic [31:0] busy_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q <= '0;
        end else if (state_q != StIdle && busy_q != 32'hFFFF_FFFF) begin
            busy_q <= busy_q + 32'd1;
        end
    end

    assign busy_cycles = busy_q;
`else
    assign busy_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario bench for mem_arbiter: read/write bursts, contention, backpressure, reset, busy counter.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        c0_req_valid, c0_req_opcode, c0_req_ack, c0_wr_valid, c0_wr_ready;
    logic        c0_rd_valid, c0_rd_ready;
    logic [7:0]  c0_req_len;
    logic [31:0] c0_req_addr;
    logic [63:0] c0_wr_bits, c0_rd_bits;
    logic        c1_req_valid, c1_req_opcode, c1_req_ack, c1_wr_valid, c1_wr_ready;
    logic        c1_rd_valid, c1_rd_ready;
    logic [7:0]  c1_req_len;
    logic [31:0] c1_req_addr;
    logic [63:0] c1_wr_bits, c1_rd_bits;
    logic        mem_req_valid, mem_req_opcode, mem_wr_valid, mem_rd_valid, mem_rd_ready;
    logic [7:0]  mem_req_len;
    logic [31:0] mem_req_addr;
    logic [63:0] mem_wr_bits, mem_rd_bits;
    logic [31:0] busy_cycles;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] rd_q[$];
    logic [63:0] wr_q[$];

    wire [145:0] all_outs = {mem_req_valid, mem_req_opcode, mem_req_len, mem_req_addr,
                             mem_wr_valid, mem_wr_bits, mem_rd_ready, c0_req_ack, c1_req_ack,
                             c0_wr_ready, c1_wr_ready, c0_rd_valid, c1_rd_valid, busy_cycles};

    always #5 clock = ~clock;

    mem_arbiter dut (
        .clock          (clock),
        .reset          (reset),
        .c0_req_valid   (c0_req_valid),
        .c0_req_opcode  (c0_req_opcode),
        .c0_req_len     (c0_req_len),
        .c0_req_addr    (c0_req_addr),
        .c0_req_ack     (c0_req_ack),
        .c0_wr_valid    (c0_wr_valid),
        .c0_wr_bits     (c0_wr_bits),
        .c0_wr_ready    (c0_wr_ready),
        .c0_rd_valid    (c0_rd_valid),
        .c0_rd_bits     (c0_rd_bits),
        .c0_rd_ready    (c0_rd_ready),
        .c1_req_valid   (c1_req_valid),
        .c1_req_opcode  (c1_req_opcode),
        .c1_req_len     (c1_req_len),
        .c1_req_addr    (c1_req_addr),
        .c1_req_ack     (c1_req_ack),
        .c1_wr_valid    (c1_wr_valid),
        .c1_wr_bits     (c1_wr_bits),
        .c1_wr_ready    (c1_wr_ready),
        .c1_rd_valid    (c1_rd_valid),
        .c1_rd_bits     (c1_rd_bits),
        .c1_rd_ready    (c1_rd_ready),
        .mem_req_valid  (mem_req_valid),
        .mem_req_opcode (mem_req_opcode),
        .mem_req_len    (mem_req_len),
        .mem_req_addr   (mem_req_addr),
        .mem_wr_valid   (mem_wr_valid),
        .mem_wr_bits    (mem_wr_bits),
        .mem_rd_valid   (mem_rd_valid),
        .mem_rd_bits    (mem_rd_bits),
        .mem_rd_ready   (mem_rd_ready),
        .busy_cycles    (busy_cycles)
    );

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        c0_req_valid = 0; c0_req_opcode = 0; c0_req_len = '0; c0_req_addr = '0;
        c0_wr_valid  = 0; c0_wr_bits = '0; c0_rd_ready = 0;
        c1_req_valid = 0; c1_req_opcode = 0; c1_req_len = '0; c1_req_addr = '0;
        c1_wr_valid  = 0; c1_wr_bits = '0; c1_rd_ready = 0;
        mem_rd_valid = 0; mem_rd_bits = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        cyc();
        cyc();
        n_tests++;
        if (all_outs !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h required 0", all_outs);
        end
        reset = 0;
        cyc();
        n_tests++;
        if (all_outs !== '0) begin
            n_fail++; $display("FAIL idle_outputs: got %h required 0", all_outs);
        end
    endtask

    task automatic test_read_single();
        int beat = 0;
        int got = 0;
        logic [63:0] exp;
        c0_req_valid = 1; c0_req_opcode = 0; c0_req_len = 8'd3; c0_req_addr = 32'h1000;
        #1;
        n_tests++;
        if (mem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL rd_req_early: got %b required 0", mem_req_valid);
        end
        cyc();
        n_tests++;
        if ({mem_req_valid, mem_req_opcode, mem_req_len, mem_req_addr, c0_req_ack, c1_req_ack}
            !== {1'b1, 1'b0, 8'd3, 32'h1000, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL rd_req: got v=%b op=%b len=%0d addr=%h ack=%b%b required 1 0 3 1000 10",
                     mem_req_valid, mem_req_opcode, mem_req_len, mem_req_addr, c0_req_ack,
                     c1_req_ack);
        end
        c0_req_valid = 0;
        c0_rd_ready  = 1;
        for (int i = 0; i < 4; i++) rd_q.push_back(64'hA + 64'(i));
        cyc();
        for (int k = 0; k < 40 && got < 4; k++) begin
            mem_rd_valid = (beat < 4);
            mem_rd_bits  = 64'hA + 64'(beat);
            #1;
            n_tests++;
            if (c1_rd_valid !== 1'b0) begin
                n_fail++; $display("FAIL rd_nonowner: got %b required 0", c1_rd_valid);
            end
            if (c0_rd_valid === 1'b1) begin
                got++;
                n_tests++;
                if (rd_q.size() == 0) begin
                    n_fail++; $display("FAIL rd_extra_beat: got %h required none", c0_rd_bits);
                end else begin
                    exp = rd_q.pop_front();
                    if (c0_rd_bits !== exp) begin
                        n_fail++; $display("FAIL rd_data: got %h required %h", c0_rd_bits, exp);
                    end
                end
            end
            if (mem_rd_valid && mem_rd_ready) beat++;
            cyc();
        end
        mem_rd_valid = 0;
        #1;
        n_tests++;
        if (got != 4) begin
            n_fail++; $display("FAIL rd_beats: got %0d required 4", got);
        end
        n_tests++;
        if (mem_rd_ready !== 1'b0) begin
            n_fail++; $display("FAIL rd_back_idle: mem_rd_ready got %b required 0", mem_rd_ready);
        end
        c0_rd_ready = 0;
        rd_q.delete();
    endtask

    task automatic test_contention();
        idle_inputs();
        reset = 1;
        c0_req_valid = 1; c0_req_len = 0; c0_req_addr = 32'h100;
        c1_req_valid = 1; c1_req_len = 0; c1_req_addr = 32'h200;
        c0_rd_ready  = 1;
        cyc();
        reset = 0;
        cyc();
        n_tests++;
        if ({c0_req_ack, c1_req_ack, mem_req_addr} !== {1'b1, 1'b0, 32'h100}) begin
            n_fail++;
            $display("FAIL tie_first: got ack=%b%b addr=%h required 10 100", c0_req_ack,
                     c1_req_ack, mem_req_addr);
        end
        cyc();
        mem_rd_valid = 1; mem_rd_bits = 64'hC0;
        #1;
        n_tests++;
        if ({c0_rd_valid, c1_rd_valid, c0_rd_bits} !== {1'b1, 1'b0, 64'hC0}) begin
            n_fail++;
            $display("FAIL tie_c0_beat: got v=%b%b d=%h required 10 c0", c0_rd_valid,
                     c1_rd_valid, c0_rd_bits);
        end
        cyc();
        mem_rd_valid = 0;
        #1;
        n_tests++;
        if ({mem_req_valid, c0_req_ack, c1_req_ack} !== 3'b000) begin
            n_fail++; $display("FAIL idle_gap: got %b required 000",
                               {mem_req_valid, c0_req_ack, c1_req_ack});
        end
        cyc();
        n_tests++;
        if ({c0_req_ack, c1_req_ack, mem_req_addr} !== {1'b0, 1'b1, 32'h200}) begin
            n_fail++;
            $display("FAIL tie_second: got ack=%b%b addr=%h required 01 200", c0_req_ack,
                     c1_req_ack, mem_req_addr);
        end
        c1_req_valid = 0;
        c1_rd_ready  = 1;
        cyc();
        mem_rd_valid = 1; mem_rd_bits = 64'hC1;
        #1;
        n_tests++;
        if ({c0_rd_valid, c1_rd_valid, c1_rd_bits} !== {1'b0, 1'b1, 64'hC1}) begin
            n_fail++;
            $display("FAIL tie_c1_beat: got v=%b%b d=%h required 01 c1", c0_rd_valid,
                     c1_rd_valid, c1_rd_bits);
        end
        cyc();
        mem_rd_valid = 0;
        cyc();
        n_tests++;
        if ({c0_req_ack, c1_req_ack} !== 2'b10) begin
            n_fail++; $display("FAIL tie_third: got ack=%b%b required 10", c0_req_ack, c1_req_ack);
        end
        c0_req_valid = 0;
        cyc();
        mem_rd_valid = 1;
        cyc();
        mem_rd_valid = 0;
        idle_inputs();
        cyc();
    endtask

    task automatic test_write_single();
        int idx = 0;
        int got = 0;
        logic [63:0] exp;
        logic [63:0] wdata [3];
        wdata[0] = 64'h11; wdata[1] = 64'h22; wdata[2] = 64'h33;
        idle_inputs();
        c1_req_valid = 1; c1_req_opcode = 1; c1_req_len = 8'd1; c1_req_addr = 32'h2000;
        c0_wr_valid  = 1; c0_wr_bits = 64'hDEAD;
        cyc();
        n_tests++;
        if ({mem_req_valid, mem_req_opcode, mem_req_len, c1_req_ack, c0_req_ack, mem_wr_valid}
            !== {1'b1, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL wr_req: got v=%b op=%b len=%0d ack1=%b ack0=%b wv=%b required 1 1 1 1 0 0",
                     mem_req_valid, mem_req_opcode, mem_req_len, c1_req_ack, c0_req_ack,
                     mem_wr_valid);
        end
        c1_req_valid = 0;
        wr_q.push_back(wdata[0]);
        wr_q.push_back(wdata[1]);
        cyc();
        for (int k = 0; k < 40 && got < 2; k++) begin
            c1_wr_valid = 1;
            c1_wr_bits  = wdata[(idx < 2) ? idx : 2];
            #1;
            n_tests++;
            if (c0_wr_ready !== 1'b0) begin
                n_fail++; $display("FAIL wr_nonowner_ready: got %b required 0", c0_wr_ready);
            end
            if (mem_wr_valid === 1'b1) begin
                got++;
                n_tests++;
                if (wr_q.size() == 0) begin
                    n_fail++; $display("FAIL wr_extra_beat: got %h required none", mem_wr_bits);
                end else begin
                    exp = wr_q.pop_front();
                    if (mem_wr_bits !== exp) begin
                        n_fail++; $display("FAIL wr_data: got %h required %h", mem_wr_bits, exp);
                    end
                end
            end
            if (c1_wr_ready) idx++;
            cyc();
        end
        c1_wr_bits = wdata[2];
        #1;
        n_tests++;
        if (got != 2) begin
            n_fail++; $display("FAIL wr_beats: got %0d required 2", got);
        end
        n_tests++;
        if ({mem_wr_valid, c1_wr_ready, c0_wr_ready} !== 3'b000) begin
            n_fail++; $display("FAIL wr_back_idle: got %b required 000",
                               {mem_wr_valid, c1_wr_ready, c0_wr_ready});
        end
        wr_q.delete();
        idle_inputs();
        cyc();
    endtask

    task automatic test_backpressure();
        int beat = 0;
        int got = 0;
        logic [63:0] exp;
        logic [63:0] bdata [2];
        bdata[0] = 64'h55; bdata[1] = 64'h66;
        idle_inputs();
        c0_req_valid = 1; c0_req_len = 8'd1; c0_req_addr = 32'h3000;
        cyc();
        c0_req_valid = 0;
        cyc();
        for (int s = 0; s < 3; s++) begin
            mem_rd_valid = 1; mem_rd_bits = bdata[0];
            #1;
            n_tests++;
            if ({mem_rd_ready, c0_rd_valid} !== 2'b01) begin
                n_fail++; $display("FAIL bp_stall: got rdy=%b v=%b required 0 1", mem_rd_ready,
                                   c0_rd_valid);
            end
            cyc();
        end
        rd_q.push_back(bdata[0]);
        rd_q.push_back(bdata[1]);
        c0_rd_ready = 1;
        for (int k = 0; k < 40 && got < 2; k++) begin
            mem_rd_valid = (beat < 2);
            mem_rd_bits  = bdata[(beat < 2) ? beat : 0];
            #1;
            if (c0_rd_valid === 1'b1) begin
                got++;
                n_tests++;
                if (rd_q.size() == 0) begin
                    n_fail++; $display("FAIL bp_extra_beat: got %h required none", c0_rd_bits);
                end else begin
                    exp = rd_q.pop_front();
                    if (c0_rd_bits !== exp) begin
                        n_fail++; $display("FAIL bp_data: got %h required %h", c0_rd_bits, exp);
                    end
                end
            end
            if (mem_rd_valid && mem_rd_ready) beat++;
            cyc();
        end
        mem_rd_valid = 0;
        #1;
        n_tests++;
        if (got != 2) begin
            n_fail++; $display("FAIL bp_beats: got %0d required 2", got);
        end
        n_tests++;
        if (mem_rd_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_back_idle: got %b required 0", mem_rd_ready);
        end
        rd_q.delete();
        idle_inputs();
        cyc();
    endtask

    task automatic test_reset_mid_read();
        int beat = 0;
        idle_inputs();
        c0_req_valid = 1; c0_req_len = 8'd7; c0_req_addr = 32'h4000;
        cyc();
        c0_req_valid = 0;
        c0_rd_ready  = 1;
        cyc();
        for (int k = 0; k < 20 && beat < 2; k++) begin
            mem_rd_valid = 1; mem_rd_bits = 64'h100 + 64'(beat);
            #1;
            if (mem_rd_valid && mem_rd_ready) beat++;
            cyc();
        end
        reset = 1;
        cyc();
        n_tests++;
        if (all_outs !== '0) begin
            n_fail++; $display("FAIL mid_reset_outputs: got %h required 0", all_outs);
        end
        reset = 0;
        c1_req_valid = 1; c1_req_len = 8'd0; c1_req_addr = 32'h5000;
        #1;
        n_tests++;
        if ({mem_rd_ready, c0_rd_valid} !== 2'b00) begin
            n_fail++; $display("FAIL mid_reset_drop: got %b required 00",
                               {mem_rd_ready, c0_rd_valid});
        end
        cyc();
        n_tests++;
        if ({c0_req_ack, c1_req_ack, mem_req_addr} !== {1'b0, 1'b1, 32'h5000}) begin
            n_fail++;
            $display("FAIL mid_reset_regrant: got ack=%b%b addr=%h required 01 5000", c0_req_ack,
                     c1_req_ack, mem_req_addr);
        end
        c1_req_valid = 0;
        c1_rd_ready  = 1;
        cyc();
        mem_rd_bits = 64'h77;
        #1;
        n_tests++;
        if ({c1_rd_valid, c0_rd_valid, c1_rd_bits} !== {1'b1, 1'b0, 64'h77}) begin
            n_fail++; $display("FAIL mid_reset_c1_beat: got v=%b%b d=%h required 10 77",
                               c1_rd_valid, c0_rd_valid, c1_rd_bits);
        end
        cyc();
        idle_inputs();
        cyc();
    endtask

    task automatic test_busy_count();
        logic [31:0] exp_busy;
`ifdef MEM_ARB_BUSY_CNT_EN
        exp_busy = 32'd2;
`else
        exp_busy = 32'd0;
`endif
        idle_inputs();
        reset = 1;
        cyc();
        reset = 0;
        c0_req_valid = 1; c0_req_opcode = 1; c0_req_len = 8'd0; c0_req_addr = 32'h6000;
        c0_wr_valid  = 1; c0_wr_bits = 64'h99;
        cyc();
        c0_req_valid = 0;
        cyc();
        n_tests++;
        if ({mem_wr_valid, mem_wr_bits} !== {1'b1, 64'h99}) begin
            n_fail++; $display("FAIL busy_wr_beat: got v=%b d=%h required 1 99", mem_wr_valid,
                               mem_wr_bits);
        end
        cyc();
        c0_wr_valid = 0;
        #1;
        n_tests++;
        if (busy_cycles !== exp_busy) begin
            n_fail++; $display("FAIL busy_count: got %0d required %0d", busy_cycles, exp_busy);
        end
        cyc();
        n_tests++;
        if (busy_cycles !== exp_busy) begin
            n_fail++; $display("FAIL busy_hold: got %0d required %0d", busy_cycles, exp_busy);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_read_single();
        test_contention();
        test_write_single();
        test_backpressure();
        test_reset_mid_read();
        test_busy_count();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-client arbiter for the single host-memory DPI port (mem_req/mem_wr/mem_rd channels) of the accelerator.
- Lets two engines (e.g. two Compute instances, or a load engine and a store engine) share MemDPI.
- Round-robin grant at transaction granularity. The owner keeps the port until its full burst of len+1 beats completes.
- Sits between the engines and the top-level mem_* ports.

Parameters:
- MEM_LEN_BITS, 8, burst length field width; a burst is len+1 beats.
- MEM_ADDR_BITS, 32, memory byte address width.
- MEM_DATA_BITS, 64, beat data width.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high.
- cN_req_valid  in  1  client N (N=0,1) requests a transaction; held until ack.
- cN_req_opcode  in  1  0 = read, 1 = write.
- cN_req_len  in  MEM_LEN_BITS  beats minus one.
- cN_req_addr  in  MEM_ADDR_BITS  start address.
- cN_req_ack  out  1  one-cycle pulse: request issued to memory.
- cN_wr_valid  in  1  client write beat.
- cN_wr_bits  in  MEM_DATA_BITS  write data.
- cN_wr_ready  out  1  arbiter accepts a write beat this cycle.
- cN_rd_valid  out  1  read beat for client N.
- cN_rd_bits  out  MEM_DATA_BITS  read data (broadcast; qualified by cN_rd_valid).
- cN_rd_ready  in  1  client accepts a read beat.
- mem_req_valid  out  1  request pulse to MemDPI.
- mem_req_opcode  out  1  request opcode.
- mem_req_len  out  MEM_LEN_BITS  request length.
- mem_req_addr  out  MEM_ADDR_BITS  request address.
- mem_wr_valid  out  1  write beat.
- mem_wr_bits  out  MEM_DATA_BITS  write data.
- mem_rd_valid  in  1  read beat available.
- mem_rd_bits  in  MEM_DATA_BITS  read data.
- mem_rd_ready  out  1  read beat consumed.
- busy_cycles  out  32  see Optional Feature.

Behaviour:
- FSM states: IDLE, REQ, RD, WR.
- Reset values:
  - state = IDLE, owner = 0, rr pointer = 0, beat counter = 0.
  - All outputs are 0: mem_*, cN_req_ack, cN_wr_ready, cN_rd_valid, busy_cycles.
- IDLE:
  - If any cN_req_valid is high, grant one client and go to REQ next cycle.
  - The opcode, len and addr of the granted client are latched in this cycle.
  - Both valid: grant the client selected by the rr pointer.
  - After any grant, the rr pointer points to the other client.
- REQ:
  - Registered mem_req_valid=1 with the latched fields, for exactly one cycle.
  - cN_req_ack=1 for the owner in the same cycle.
  - Next state is RD if opcode=0, WR if opcode=1. Beat counter is cleared.
- Request latency: cN_req_valid seen in IDLE at cycle t gives mem_req_valid and ack at t+1.
- Clients must drop or change cN_req_valid only after ack.
- RD:
  - mem_rd_ready = owner's cN_rd_ready.
  - Owner's cN_rd_valid = mem_rd_valid; the non-owner sees cN_rd_valid=0.
  - A beat counts when mem_rd_valid & mem_rd_ready.
  - On the beat where counter == len, go to IDLE.
- WR:
  - Owner's cN_wr_ready = 1.
  - mem_wr_valid = owner's cN_wr_valid; mem_wr_bits = owner's cN_wr_bits. No backpressure from memory.
  - A beat counts when mem_wr_valid. On the beat where counter == len, go to IDLE.
  - Non-owner: cN_wr_ready=0; its wr_valid is ignored.
- Outside RD/WR: mem_rd_ready=0, mem_wr_valid=0, all cN_wr_ready=0, all cN_rd_valid=0.
- len=0 gives a single-beat burst. len=2^MEM_LEN_BITS-1 gives 256 beats at default width; the counter is MEM_LEN_BITS wide and never wraps before the compare.
- Back-to-back transactions:
  - IDLE lasts at least one cycle between transactions.
  - A client holding valid continuously alternates with the other client when both are requesting.
- Reset mid-transaction:
  - Forces IDLE and clears the counter, owner and rr pointer.
  - Any remaining DPI read beats are dropped because mem_rd_ready is 0 in IDLE.

Optional Feature:
- Macro: MEM_ARB_BUSY_CNT_EN.
- Defined:
  - busy_cycles counts cycles with state != IDLE.
  - Saturates at 0xFFFFFFFF and clears on reset.
  - Intended to feed the RegFile event counter.
- Undefined: busy_cycles is tied to 0 and no counter logic is built.

Decomposition:
- Shared package mem_arb_pkg holds:
  - State enum typedef (IDLE/REQ/RD/WR).
  - Opcode constants MEM_OP_RD=0 and MEM_OP_WR=1.
  - Request struct typedef {opcode, len, addr}.
- One natural sub-module: mem_arb_rr2, the two-input round-robin grant logic plus pointer register.

Test Plan:
- Read, single client:
  - Stimulus: c0 reads addr 0x1000, len 3; memory returns 4 beats 0xA..0xD; c0_rd_ready held at 1.
  - Response: mem_req_valid one cycle after c0_req_valid with addr 0x1000, len 3; c0_rd_valid on the 4 beats with data 0xA..0xD; IDLE after the 4th beat; c1_rd_valid stays 0.
- Write, single client:
  - Stimulus: c1 writes len 1 with data 0x11, 0x22.
  - Response: mem_req_opcode=1; mem_wr_bits 0x11 then 0x22; return to IDLE; c0_wr_ready never asserted.
- Contention:
  - Stimulus: c0 and c1 both request at reset exit.
  - Response: c0 acked first, c1 acked after c0's burst. If c0 re-requests, c1 still wins the next tie.
- Backpressure:
  - Stimulus: read len 1 with c0_rd_ready low for 3 cycles.
  - Response: mem_rd_ready is low for those cycles; no beat is counted; both beats are delivered afterwards.
- Reset mid-read:
  - Stimulus: reset asserted after beat 2 of a len-7 read.
  - Response: next cycle all outputs are 0 and state is IDLE; a fresh c1 request is granted (rr pointer back to 0, c1 the only requester).
- Busy counter (MEM_ARB_BUSY_CNT_EN defined):
  - Stimulus: a single len-0 write with wr_valid available immediately.
  - Response: busy_cycles = 2 (REQ + WR).
